// File: rtl/video_line_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through stream FIFO carrying pixels plus SOF/EOL markers.
// Reports level, stored line count, threshold flags, sticky errors; supports flush.
module video_line_fifo #(
  parameter int DATA_WIDTH     = 24,
  parameter int DEPTH          = 2048,
  parameter int AF_MARGIN      = 4,
  parameter int AE_MARGIN      = 4,
  parameter int LINE_CNT_WIDTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       S_VALID,
  output logic                       S_READY,
  input  logic [DATA_WIDTH-1:0]      S_DATA,
  input  logic                       S_SOF,
  input  logic                       S_EOL,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [DATA_WIDTH-1:0]      M_DATA,
  output logic                       M_SOF,
  output logic                       M_EOL,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic [LINE_CNT_WIDTH-1:0]  LINES,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = DATA_WIDTH + 2;
  localparam int AF_INT = (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;
  localparam int AE_INT = (AE_MARGIN >= DEPTH) ? DEPTH : AE_MARGIN;

  localparam logic [PTR_W-1:0]          PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]          PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0]          CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]          CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]          AF_LVL    = CNT_W'(AF_INT);
  localparam logic [CNT_W-1:0]          AE_LVL    = CNT_W'(AE_INT);
  localparam logic [LINE_CNT_WIDTH-1:0] LINES_MAX = {LINE_CNT_WIDTH{1'b1}};
  localparam logic [LINE_CNT_WIDTH-1:0] LINES_MIN = {LINE_CNT_WIDTH{1'b0}};

  logic [ENT_W-1:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [LINE_CNT_WIDTH-1:0] lines_q, lines_d;
  logic                      s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic                      af_q, af_d, ae_q, ae_d;
  logic                      ovf_q, ovf_d, unf_q, unf_d;
  logic                      wr_fire_s, rd_fire_s, line_in_s, line_out_s;
  logic [ENT_W-1:0]          head_s;

  assign head_s = mem_q[rd_ptr_q];

  // Next-state for pointers, level, line count and flags; FLUSH discards both handshakes.
  always_comb begin
    wr_fire_s  = S_VALID & s_ready_q & ~FLUSH;
    rd_fire_s  = M_READY & m_valid_q & ~FLUSH;
    line_in_s  = wr_fire_s & S_EOL;
    line_out_s = rd_fire_s & head_s[DATA_WIDTH];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lines_d    = lines_q;

    if (FLUSH) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
      lines_d  = LINES_MIN;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_fire_s) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_fire_s && !rd_fire_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_fire_s && !wr_fire_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      // The line count saturates, so after saturation it under-reports on the way down.
      if (line_in_s && !line_out_s) begin
        lines_d = (lines_q == LINES_MAX) ? LINES_MAX : lines_q + LINE_CNT_WIDTH'(1);
      end else if (line_out_s && !line_in_s) begin
        lines_d = (lines_q == LINES_MIN) ? LINES_MIN : lines_q - LINE_CNT_WIDTH'(1);
      end else begin
        lines_d = lines_q;
      end
    end

    s_ready_d = (count_d != CNT_FULL);
    m_valid_d = (count_d != CNT_ZERO);
    af_d      = (count_d >= AF_LVL);
    ae_d      = (count_d <= AE_LVL);
    ovf_d     = ovf_q | (S_VALID & ~s_ready_q);
    unf_d     = unf_q | (M_READY & ~m_valid_q);
  end

  // Control registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      lines_q   <= LINES_MIN;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lines_q   <= lines_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage write port; contents survive RESET but are unreachable afterwards.
  always_ff @(posedge CLK) begin
    if (wr_fire_s && !RESET) begin
      mem_q[wr_ptr_q] <= {S_SOF, S_EOL, S_DATA};
    end
  end

  assign S_READY      = s_ready_q;
  assign M_VALID      = m_valid_q;
  assign M_DATA       = head_s[DATA_WIDTH-1:0];
  assign M_EOL        = head_s[DATA_WIDTH];
  assign M_SOF        = head_s[DATA_WIDTH+1];
  assign COUNT        = count_q;
  assign LINES        = lines_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule
